branch_history_table: RTL and testbench

Pattern history table for the fetch-stage branch predictor. It stores one 2-bit counter state per entry and indexes the table gshare-style, with PC bits XOR a global history register. It returns the stored state to the downstream 2-bit counter stage, which turns it into the prediction. It then accepts that stage's updated state at branch resolution, writes it back, and shifts the resolved outcome into the global history.

---
 rtl/branch_history_table_if.sv | 32 +++
 rtl/branch_history_table.sv | 83 ++++++++
 tb/tb_branch_history_table.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_history_table_if.sv
// Fetch-side lookup, resolution-side update and debug GHR signals of the
// gshare pattern history table, bundled as one bus.
interface branch_history_table_if #(
   parameter int INDEX_BITS = 6,
   parameter int GHR_BITS   = 4
);
   logic                  lookup_valid;
   logic [31:0]           lookup_pc;
   logic                  flush;
   logic                  pred_valid;
   logic [1:0]            pred_history;
   logic [INDEX_BITS-1:0] pred_index;
   logic                  upd_valid;
   logic [INDEX_BITS-1:0] upd_index;
   logic [1:0]            upd_history;
   logic                  upd_taken;
   logic [GHR_BITS-1:0]   ghr_out;

   // Fetch / resolution logic side: issues lookups and updates.
   modport master (
      output lookup_valid, lookup_pc, flush,
      output upd_valid, upd_index, upd_history, upd_taken,
      input  pred_valid, pred_history, pred_index, ghr_out
   );

   // Table side.
   modport slave (
      input  lookup_valid, lookup_pc, flush,
      input  upd_valid, upd_index, upd_history, upd_taken,
      output pred_valid, pred_history, pred_index, ghr_out
   );
endinterface

// File: rtl/branch_history_table.sv
// Gshare pattern history table: one 2-bit counter state per entry, indexed
// by PC[INDEX_BITS+1:2] XOR the non-speculative global history. Counter
// encoding belongs to the downstream counter stage; entries are stored and
// returned verbatim.
module branch_history_table #(
   parameter int INDEX_BITS = 6,
   parameter int GHR_BITS   = 4
) (
   input  logic                   clock,
   input  logic                   reset,
   branch_history_table_if.slave  bus
);
   localparam int ENTRIES = 1 << INDEX_BITS;

   logic [1:0]            pht_q [ENTRIES];
   logic [1:0]            pht_d [ENTRIES];
   logic [GHR_BITS-1:0]   ghr_q, ghr_d;
   logic                  pred_valid_q, pred_valid_d;
   logic [1:0]            pred_history_q, pred_history_d;
   logic [INDEX_BITS-1:0] pred_index_q, pred_index_d;

   logic [INDEX_BITS-1:0] lookup_idx;
   logic                  lookup_accept;
   logic                  fwd_hit;
   logic                  unused_pc_bits;

   // PC bits outside the index window do not participate in indexing.
   assign unused_pc_bits = ^{bus.lookup_pc[31:INDEX_BITS+2], bus.lookup_pc[1:0]};

   // Index uses the GHR held this cycle; a same-cycle shift only shows next cycle.
   always_comb begin
      lookup_idx    = bus.lookup_pc[INDEX_BITS+1:2] ^ INDEX_BITS'(ghr_q);
      lookup_accept = bus.lookup_valid && !bus.flush;
      fwd_hit       = bus.upd_valid && (bus.upd_index == lookup_idx);
   end

   // Next-state: table write-back, history shift, and prediction capture.
   always_comb begin
      pht_d          = pht_q;
      ghr_d          = ghr_q;
      pred_valid_d   = lookup_accept;
      pred_history_d = pred_history_q;
      pred_index_d   = pred_index_q;

      if (bus.upd_valid) begin
         pht_d[bus.upd_index] = bus.upd_history;
         // Dropping the MSB of {ghr, taken} shifts the oldest outcome out;
         // this also covers a single-bit history.
         ghr_d = GHR_BITS'({ghr_q, bus.upd_taken});
      end

      if (lookup_accept) begin
         pred_index_d   = lookup_idx;
         // A write landing this edge to the same entry must not be missed.
         pred_history_d = fwd_hit ? bus.upd_history : pht_q[lookup_idx];
      end
   end

   // State registers; reset clears everything immediately.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < ENTRIES; i++) begin
            pht_q[i] <= 2'b00;
         end
         ghr_q          <= '0;
         pred_valid_q   <= 1'b0;
         pred_history_q <= 2'b00;
         pred_index_q   <= '0;
      end else begin
         pht_q          <= pht_d;
         ghr_q          <= ghr_d;
         pred_valid_q   <= pred_valid_d;
         pred_history_q <= pred_history_d;
         pred_index_q   <= pred_index_d;
      end
   end

   assign bus.pred_valid   = pred_valid_q;
   assign bus.pred_history = pred_history_q;
   assign bus.pred_index   = pred_index_q;
   assign bus.ghr_out      = ghr_q;

endmodule

// File: tb/tb_branch_history_table.sv
// Directed bench for branch_history_table with hand-computed expectations.
module tb_branch_history_table;
   localparam int IB = 6;
   localparam int GB = 4;

   logic clock;
   logic reset;
   int   n_checks;
   int   n_fail;

   branch_history_table_if #(.INDEX_BITS(IB), .GHR_BITS(GB)) bif ();

   branch_history_table #(.INDEX_BITS(IB), .GHR_BITS(GB)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bif)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic idle_inputs();
      bif.lookup_valid = 1'b0;
      bif.lookup_pc    = 32'h0;
      bif.flush        = 1'b0;
      bif.upd_valid    = 1'b0;
      bif.upd_index    = '0;
      bif.upd_history  = 2'b00;
      bif.upd_taken    = 1'b0;
   endtask

   // Advance through one rising edge and settle just after it.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle_inputs();
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if (bif.pred_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_pred_valid: got %b expected 0", bif.pred_valid);
      end
      n_checks++;
      if (bif.pred_history !== 2'b00) begin
         n_fail++; $display("FAIL reset_pred_history: got %b expected 00", bif.pred_history);
      end
      n_checks++;
      if (bif.pred_index !== 6'h00) begin
         n_fail++; $display("FAIL reset_pred_index: got %h expected 00", bif.pred_index);
      end
      n_checks++;
      if (bif.ghr_out !== 4'h0) begin
         n_fail++; $display("FAIL reset_ghr: got %b expected 0000", bif.ghr_out);
      end
   endtask

   task automatic test_lookup_basic();
      bif.lookup_valid = 1'b1;
      bif.lookup_pc    = 32'h40;
      step();
      idle_inputs();
      n_checks++;
      if (bif.pred_valid !== 1'b1) begin
         n_fail++; $display("FAIL lookup_pred_valid: got %b expected 1", bif.pred_valid);
      end
      n_checks++;
      if (bif.pred_index !== 6'h10) begin
         n_fail++; $display("FAIL lookup_pred_index: got %h expected 10", bif.pred_index);
      end
      n_checks++;
      if (bif.pred_history !== 2'b00) begin
         n_fail++; $display("FAIL lookup_pred_history: got %b expected 00", bif.pred_history);
      end
      n_checks++;
      if (bif.ghr_out !== 4'h0) begin
         n_fail++; $display("FAIL lookup_ghr: got %b expected 0000", bif.ghr_out);
      end
      step();
      n_checks++;
      if (bif.pred_valid !== 1'b0) begin
         n_fail++; $display("FAIL lookup_valid_drop: got %b expected 0", bif.pred_valid);
      end
   endtask

   task automatic test_update_ghr();
      bif.upd_valid   = 1'b1;
      bif.upd_index   = 6'h10;
      bif.upd_history = 2'b10;
      bif.upd_taken   = 1'b1;
      step();
      idle_inputs();
      n_checks++;
      if (bif.ghr_out !== 4'b0001) begin
         n_fail++; $display("FAIL update_ghr: got %b expected 0001", bif.ghr_out);
      end
      // Same PC now hashes to 0x11 (unwritten).
      bif.lookup_valid = 1'b1;
      bif.lookup_pc    = 32'h40;
      step();
      n_checks++;
      if (bif.pred_index !== 6'h11) begin
         n_fail++; $display("FAIL update_idx_pc40: got %h expected 11", bif.pred_index);
      end
      n_checks++;
      if (bif.pred_history !== 2'b00) begin
         n_fail++; $display("FAIL update_hist_pc40: got %b expected 00", bif.pred_history);
      end
      // PC 0x44 -> 0x11 ^ 0x1 = 0x10, the written entry.
      bif.lookup_pc = 32'h44;
      step();
      idle_inputs();
      n_checks++;
      if (bif.pred_index !== 6'h10) begin
         n_fail++; $display("FAIL update_idx_pc44: got %h expected 10", bif.pred_index);
      end
      n_checks++;
      if (bif.pred_history !== 2'b10) begin
         n_fail++; $display("FAIL update_hist_pc44: got %b expected 10", bif.pred_history);
      end
   endtask

   task automatic test_forwarding();
      do_reset();
      bif.lookup_valid = 1'b1;
      bif.lookup_pc    = 32'h14;
      bif.upd_valid    = 1'b1;
      bif.upd_index    = 6'h05;
      bif.upd_history  = 2'b11;
      bif.upd_taken    = 1'b0;
      step();
      bif.upd_valid = 1'b0;
      n_checks++;
      if (bif.pred_index !== 6'h05) begin
         n_fail++; $display("FAIL fwd_index: got %h expected 05", bif.pred_index);
      end
      n_checks++;
      if (bif.pred_history !== 2'b11) begin
         n_fail++; $display("FAIL fwd_history: got %b expected 11", bif.pred_history);
      end
      step();
      idle_inputs();
      n_checks++;
      if (bif.pred_history !== 2'b11) begin
         n_fail++; $display("FAIL fwd_repeat_history: got %b expected 11", bif.pred_history);
      end
      n_checks++;
      if (bif.pred_valid !== 1'b1) begin
         n_fail++; $display("FAIL fwd_repeat_valid: got %b expected 1", bif.pred_valid);
      end
   endtask

   task automatic test_flush();
      // Last accepted prediction: index 0x05, history 11.
      bif.lookup_valid = 1'b1;
      bif.lookup_pc    = 32'h40;
      bif.flush        = 1'b1;
      bif.upd_valid    = 1'b1;
      bif.upd_index    = 6'h20;
      bif.upd_history  = 2'b01;
      bif.upd_taken    = 1'b0;
      step();
      idle_inputs();
      n_checks++;
      if (bif.pred_valid !== 1'b0) begin
         n_fail++; $display("FAIL flush_valid: got %b expected 0", bif.pred_valid);
      end
      n_checks++;
      if (bif.pred_index !== 6'h05) begin
         n_fail++; $display("FAIL flush_index_hold: got %h expected 05", bif.pred_index);
      end
      n_checks++;
      if (bif.pred_history !== 2'b11) begin
         n_fail++; $display("FAIL flush_history_hold: got %b expected 11", bif.pred_history);
      end
      bif.lookup_valid = 1'b1;
      bif.lookup_pc    = 32'h80;
      step();
      idle_inputs();
      n_checks++;
      if (bif.pred_index !== 6'h20) begin
         n_fail++; $display("FAIL flush_upd_index: got %h expected 20", bif.pred_index);
      end
      n_checks++;
      if (bif.pred_history !== 2'b01) begin
         n_fail++; $display("FAIL flush_upd_history: got %b expected 01", bif.pred_history);
      end
   endtask

   task automatic test_ghr_wrap();
      logic [3:0] exp_ghr [5];
      exp_ghr = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hF};
      for (int i = 0; i < 5; i++) begin
         bif.upd_valid   = 1'b1;
         bif.upd_index   = 6'h3F;
         bif.upd_history = 2'b10;
         bif.upd_taken   = 1'b1;
         step();
         n_checks++;
         if (bif.ghr_out !== exp_ghr[i]) begin
            n_fail++; $display("FAIL ghr_wrap_step%0d: got %b expected %b", i, bif.ghr_out, exp_ghr[i]);
         end
      end
      bif.upd_taken = 1'b0;
      step();
      idle_inputs();
      n_checks++;
      if (bif.ghr_out !== 4'b1110) begin
         n_fail++; $display("FAIL ghr_wrap_not_taken: got %b expected 1110", bif.ghr_out);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] pcs [3];
      // ghr 1110 -> 1101 -> 1011
      bif.upd_valid   = 1'b1;
      bif.upd_index   = 6'h2A;
      bif.upd_history = 2'b10;
      bif.upd_taken   = 1'b1;
      step();
      bif.upd_index   = 6'h15;
      bif.upd_history = 2'b11;
      step();
      idle_inputs();
      n_checks++;
      if (bif.ghr_out !== 4'b1011) begin
         n_fail++; $display("FAIL mid_pre_ghr: got %b expected 1011", bif.ghr_out);
      end
      // 0x10 ^ 0xB = 0x1B
      bif.lookup_valid = 1'b1;
      bif.lookup_pc    = 32'h40;
      step();
      idle_inputs();
      n_checks++;
      if (bif.pred_valid !== 1'b1 || bif.pred_index !== 6'h1B) begin
         n_fail++; $display("FAIL mid_pre_lookup: got v=%b idx=%h expected v=1 idx=1b", bif.pred_valid, bif.pred_index);
      end
      // Pending update in the reset cycle, then reset mid-cycle.
      bif.upd_valid   = 1'b1;
      bif.upd_index   = 6'h2A;
      bif.upd_history = 2'b01;
      bif.upd_taken   = 1'b1;
      #2;
      reset = 1'b1;
      #1;
      n_checks++;
      if (bif.pred_valid !== 1'b0) begin
         n_fail++; $display("FAIL mid_async_valid: got %b expected 0", bif.pred_valid);
      end
      n_checks++;
      if (bif.ghr_out !== 4'h0) begin
         n_fail++; $display("FAIL mid_async_ghr: got %b expected 0000", bif.ghr_out);
      end
      step();
      reset = 1'b0;
      idle_inputs();
      pcs = '{32'hA8, 32'h54, 32'h40};
      for (int i = 0; i < 3; i++) begin
         bif.lookup_valid = 1'b1;
         bif.lookup_pc    = pcs[i];
         step();
         n_checks++;
         if (bif.pred_valid !== 1'b1 || bif.pred_history !== 2'b00) begin
            n_fail++; $display("FAIL mid_post_lookup%0d: got v=%b hist=%b expected v=1 hist=00", i, bif.pred_valid, bif.pred_history);
         end
      end
      idle_inputs();
      n_checks++;
      if (bif.ghr_out !== 4'h0) begin
         n_fail++; $display("FAIL mid_post_ghr: got %b expected 0000", bif.ghr_out);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset    = 1'b1;
      idle_inputs();
      #1;
      test_reset();
      test_lookup_basic();
      test_update_ghr();
      test_forwarding();
      test_flush();
      test_ghr_wrap();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
